// File: rtl/ysyx_23060203_imem_axi_rd_if.sv
// AXI4 read-only bus (AR + R channels) between the ICache refill master and the
// instruction memory model.
interface ysyx_23060203_imem_axi_rd_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/ysyx_23060203_imem_axi_rd.sv
// AXI4 read-only instruction memory model: word ROM with programmable first-beat latency,
// FIXED/INCR/WRAP bursts, one outstanding transaction. Define YSYX_23060203_IMEM_BUBBLE_EN
// to insert LFSR-driven rvalid bubbles and arready holds.
module ysyx_23060203_imem_axi_rd #(
  parameter logic [31:0] BASE      = 32'h8000_0000,
  parameter int unsigned DEPTH     = 32768,
  parameter int unsigned LAT       = 2,
  parameter string       INIT_FILE = "imem.hex"
) (
  input logic                        clock,
  input logic                        reset,
  ysyx_23060203_imem_axi_rd_if.slave bus
);

  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] WinBytes = 33'(DEPTH) << 2;
  localparam logic [15:0] LatLoad  = (LAT > 1) ? 16'(LAT - 1) : 16'd0;
  localparam logic        LatOne   = (LAT <= 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StBeat = 2'd2;

  logic [31:0] mem [DEPTH];

  logic [1:0]  state_q;
  logic [15:0] cnt_q;
  logic [31:0] addr_q;
  logic [3:0]  id_q;
  logic [7:0]  len_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic [7:0]  beat_q;

  logic        arready_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        rlast_q;
  logic [3:0]  rid_q;

  logic bubble;
  logic hold_ar;

`ifdef YSYX_23060203_IMEM_BUBBLE_EN
  logic [15:0] lfsr_q;

  // Fibonacci form of x^16+x^14+x^13+x^11+1.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign bubble  = lfsr_q[0];
  assign hold_ar = lfsr_q[1];
`else
  assign bubble  = 1'b0;
  assign hold_ar = 1'b0;
`endif

  logic ar_hs;
  logic r_hs;

  assign ar_hs = bus.arvalid & arready_q;
  assign r_hs  = rvalid_q & bus.rready;

  // Address of the beat following addr_q.
  logic [31:0] wrap_mask;
  logic [31:0] nxt_addr;

  always_comb begin
    wrap_mask = ((32'(len_q) + 32'd1) << 2) - 32'd1;
    unique case (burst_q)
      2'b00:   nxt_addr = addr_q;
      2'b10:   nxt_addr = (addr_q & ~wrap_mask) | ((addr_q + 32'd4) & wrap_mask);
      default: nxt_addr = addr_q + 32'd4;
    endcase
  end

  // Attributes of the beat about to be presented: straight from AR when the first beat
  // leaves IDLE, the advanced address after an accepted beat, else the latched values.
  logic [31:0] src_addr;
  logic [3:0]  src_id;
  logic [7:0]  src_len;
  logic [2:0]  src_size;
  logic [1:0]  src_burst;
  logic [7:0]  src_beat;

  always_comb begin
    src_addr  = addr_q;
    src_id    = id_q;
    src_len   = len_q;
    src_size  = size_q;
    src_burst = burst_q;
    src_beat  = beat_q;
    if (state_q == StIdle) begin
      src_addr  = bus.araddr;
      src_id    = bus.arid;
      src_len   = bus.arlen;
      src_size  = bus.arsize;
      src_burst = bus.arburst;
      src_beat  = 8'd0;
    end else if (state_q == StBeat && rvalid_q) begin
      src_addr = nxt_addr;
      src_beat = beat_q + 8'd1;
    end
  end

  logic [32:0]     offset;
  logic            in_range;
  logic            len_ok;
  logic            slv_err;
  logic [IdxW-1:0] idx;
  logic [1:0]      beat_resp;
  logic [31:0]     beat_data;
  logic            beat_last;

  always_comb begin
    // Addresses below BASE wrap to a huge offset and fall out of the window.
    offset    = {1'b0, src_addr} - {1'b0, BASE};
    in_range  = offset < WinBytes;
    idx       = offset[IdxW+1:2];
    len_ok    = (src_len == 8'd1) | (src_len == 8'd3) | (src_len == 8'd7) | (src_len == 8'd15);
    slv_err   = (src_size != 3'b010) | (src_burst == 2'b11) | ((src_burst == 2'b10) & ~len_ok);
    beat_resp = ~in_range ? 2'b11 : (slv_err ? 2'b10 : 2'b00);
    beat_data = (beat_resp == 2'b00) ? mem[idx] : 32'd0;
    beat_last = (src_beat == src_len);
  end

  logic present;

  always_comb begin
    present = 1'b0;
    unique case (state_q)
      StIdle:  present = ar_hs & LatOne;
      StWait:  present = (cnt_q <= 16'd1);
      // ~rvalid_q inside BEAT only happens during a bubble.
      StBeat:  present = (r_hs & ~rlast_q & ~bubble) | ~rvalid_q;
      default: present = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 16'd0;
      addr_q    <= 32'd0;
      id_q      <= 4'd0;
      len_q     <= 8'd0;
      size_q    <= 3'd0;
      burst_q   <= 2'd0;
      beat_q    <= 8'd0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'd0;
      rlast_q   <= 1'b0;
      rid_q     <= 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          arready_q <= ~hold_ar;
          if (ar_hs) begin
            addr_q    <= bus.araddr;
            id_q      <= bus.arid;
            len_q     <= bus.arlen;
            size_q    <= bus.arsize;
            burst_q   <= bus.arburst;
            beat_q    <= 8'd0;
            cnt_q     <= LatLoad;
            arready_q <= 1'b0;
            state_q   <= LatOne ? StBeat : StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 16'd1;
          if (cnt_q <= 16'd1) state_q <= StBeat;
        end
        StBeat: begin
          if (r_hs) begin
            if (rlast_q) begin
              state_q   <= StIdle;
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
            end else begin
              addr_q <= nxt_addr;
              beat_q <= beat_q + 8'd1;
              if (bubble) rvalid_q <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      if (present) begin
        rvalid_q <= 1'b1;
        rdata_q  <= beat_data;
        rresp_q  <= beat_resp;
        rlast_q  <= beat_last;
        rid_q    <= src_id;
      end
    end
  end

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rlast   = rlast_q;
  assign bus.rid     = rid_q;

endmodule
